// File: rtl/bn_res_pipe.sv
// -----------------------------------------------------------------------------
// bn_res_pipe
//
// Per-channel batch-norm plus residual add, three register stages deep:
//     out = sat( round((bn_a * x + bn_b) >>> FRAC_BITS) + res )
// x is an unsigned activation. Every intermediate is sign-extended to a width
// that cannot overflow, so the only clipping happens in the final saturation.
//
// Stage S1 holds the product, S2 the biased/rounded/shifted value, and S3 the
// saturated result that drives data_out. One global enable stalls all stages
// together whenever the output holds a beat the consumer has not taken yet.
//
// Optional feature:
//     BN_RES_RELU_EN  when defined, negative results are forced to 0 in S3.
//                     A channel forced to 0 this way is not counted as clipped.
//
// Ports:
//     clk             rising-edge clock
//     rstn            asynchronous active-low reset
//     data_in_valid   input beat offered
//     data_in_ready   input beat accepted when both valid and ready are high
//     data_in         CHANNEL_NUM x IN_WIDTH unsigned activations
//     bn_a            CHANNEL_NUM x PARA_WIDTH signed scale (read at S1 entry)
//     bn_b            CHANNEL_NUM x PARA_WIDTH signed bias  (read at S2 entry)
//     res             CHANNEL_NUM x DATA_WIDTH signed residual, taken with data_in
//     data_out_valid  output beat present
//     data_out_ready  downstream accepts the output beat
//     data_out        CHANNEL_NUM x DATA_WIDTH signed result
//     sat_count       saturating count of output beats with any clipped channel
// -----------------------------------------------------------------------------
module bn_res_pipe #(
    parameter int IN_WIDTH    = 6,
    parameter int DATA_WIDTH  = 16,
    parameter int PARA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int FRAC_BITS   = 8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   data_in_valid,
    output logic                                   data_in_ready,
    input  logic [CHANNEL_NUM-1:0][IN_WIDTH-1:0]   data_in,
    input  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bn_a,
    input  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bn_b,
    input  logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] res,
    output logic                                   data_out_valid,
    input  logic                                   data_out_ready,
    output logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] data_out,
    output logic [15:0]                            sat_count
);

    // The product of a signed coefficient and a zero-extended activation
    // needs PARA_WIDTH + IN_WIDTH + 1 bits. Adding the bias and the rounding
    // constant needs two more bits. The residual add needs one more bit than
    // the wider of the two addends.
    localparam int PROD_W = PARA_WIDTH + IN_WIDTH + 1;
    localparam int BIAS_W = PROD_W + 2;
    localparam int ACC_W  = ((BIAS_W > DATA_WIDTH) ? BIAS_W : DATA_WIDTH) + 1;

    localparam logic signed [BIAS_W-1:0] ROUND_C = BIAS_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0]  SAT_MIN = ~SAT_MAX;

    logic en;

    logic                                   s1Valid_q;
    logic signed [PROD_W-1:0]               s1Prod_q [CHANNEL_NUM];
    logic signed [PROD_W-1:0]               s1Prod_d [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] s1Res_q;

    logic                                   s2Valid_q;
    logic signed [BIAS_W-1:0]               s2Val_q [CHANNEL_NUM];
    logic signed [BIAS_W-1:0]               s2Val_d [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] s2Res_q;

    logic                                   s3Valid_q;
    logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] s3Out_q;
    logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] s3Out_d;
    logic signed [ACC_W-1:0]                acc3 [CHANNEL_NUM];
    logic                                   anyClip;

    logic [15:0] satCount_q;
    logic [15:0] satCount_d;

    // The whole pipe moves as one: it advances unless the output beat is
    // stuck waiting for the consumer. This also makes input ready a pure
    // function of the output handshake.
    assign en             = !s3Valid_q || data_out_ready;
    assign data_in_ready  = en;
    assign data_out_valid = s3Valid_q;
    assign data_out       = s3Out_q;
    assign sat_count      = satCount_q;

    // S1 next value: the signed product. Both operands are cast to the full
    // product width first so the multiply itself is done at that width.
    always_comb begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            s1Prod_d[c] = PROD_W'($signed(bn_a[c])) * $signed(PROD_W'({1'b0, data_in[c]}));
        end
    end

    // S2 next value: add the bias and the half-LSB rounding constant, then
    // shift arithmetically. Together this rounds half toward +inf.
    always_comb begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            s2Val_d[c] = (BIAS_W'(s1Prod_q[c]) + BIAS_W'($signed(bn_b[c])) + ROUND_C) >>> FRAC_BITS;
        end
    end

    // S3 next value: add the residual, then saturate to the output range.
    // anyClip marks a beat in which at least one channel hit a rail.
    always_comb begin
        anyClip = 1'b0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            acc3[c] = ACC_W'(s2Val_q[c]) + ACC_W'($signed(s2Res_q[c]));
            if (acc3[c] > SAT_MAX) begin
                s3Out_d[c] = SAT_MAX[DATA_WIDTH-1:0];
                anyClip    = 1'b1;
            end
`ifdef BN_RES_RELU_EN
            // Any negative value, including one below the lower rail, becomes
            // zero. It is therefore never reported as clipped.
            else if (acc3[c][ACC_W-1]) begin
                s3Out_d[c] = '0;
            end
`else
            else if (acc3[c] < SAT_MIN) begin
                s3Out_d[c] = SAT_MIN[DATA_WIDTH-1:0];
                anyClip    = 1'b1;
            end
`endif
            else begin
                s3Out_d[c] = acc3[c][DATA_WIDTH-1:0];
            end
        end
    end

    // The clip counter only counts real beats entering S3. It sticks at
    // all-ones instead of wrapping.
    always_comb begin
        satCount_d = satCount_q;
        if (s2Valid_q && anyClip && (satCount_q != 16'hFFFF)) begin
            satCount_d = satCount_q + 16'd1;
        end
    end

    // Stage registers. Data shifts on every enabled edge, bubbles included.
    // Bubble contents are therefore a deterministic function of the inputs,
    // and the valid bits alone tell beats from bubbles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            s3Valid_q  <= 1'b0;
            s1Res_q    <= '0;
            s2Res_q    <= '0;
            s3Out_q    <= '0;
            satCount_q <= '0;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                s1Prod_q[c] <= '0;
                s2Val_q[c]  <= '0;
            end
        end else if (en) begin
            s1Valid_q  <= data_in_valid;
            s2Valid_q  <= s1Valid_q;
            s3Valid_q  <= s2Valid_q;
            s1Res_q    <= res;
            s2Res_q    <= s1Res_q;
            s3Out_q    <= s3Out_d;
            satCount_q <= satCount_d;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                s1Prod_q[c] <= s1Prod_d[c];
                s2Val_q[c]  <= s2Val_d[c];
            end
        end
    end

endmodule

// File: tb/tb_bn_res_pipe.sv
// -----------------------------------------------------------------------------
// tb_bn_res_pipe
//
// Directed bench for bn_res_pipe, built with 4 channels and FRAC_BITS = 8.
// Expected results were worked out by hand from the transfer function. The
// streaming test uses a small closed-form model, out = 2*x + res, because
// bn_a = 512 and bn_b = 0 in that test.
// -----------------------------------------------------------------------------
module tb_bn_res_pipe;

    localparam int CH = 4;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [CH-1:0][5:0]    data_in;
    logic [CH-1:0][15:0]   bn_a;
    logic [CH-1:0][15:0]   bn_b;
    logic [CH-1:0][15:0]   res;
    logic                  data_out_valid;
    logic                  data_out_ready;
    logic [CH-1:0][15:0]   data_out;
    logic [15:0]           sat_count;

    int errCount   = 0;
    int checkCount = 0;

    logic        collectEn = 1'b0;
    int          gotCount  = 0;
    logic [63:0] expQ [$];

    always #5 clk = ~clk;

    bn_res_pipe #(
        .IN_WIDTH   (6),
        .DATA_WIDTH (16),
        .PARA_WIDTH (16),
        .CHANNEL_NUM(CH),
        .FRAC_BITS  (8)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_in       (data_in),
        .bn_a          (bn_a),
        .bn_b          (bn_b),
        .res           (res),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out      (data_out),
        .sat_count     (sat_count)
    );

    // Single comparison point: every check is counted here and reported
    // here when it mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives the same coefficients, activation and residual on every
    // channel, and offers the beat.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [5:0] x, input logic [15:0] r);
        for (int c = 0; c < CH; c++) begin
            bn_a[c]    = a;
            bn_b[c]    = b;
            data_in[c] = x;
            res[c]     = r;
        end
        data_in_valid = 1'b1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Sends one beat with the output always ready. Checks that the beat is
    // not yet visible after the accept edge or the one after it, and that it
    // shows up with the right data after the second edge past acceptance.
    task automatic runSingle(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [5:0] x, input logic [15:0] r,
                             input logic [15:0] expVal, input logic [15:0] expSat);
        data_out_ready = 1'b1;
        applyStimulus(a, b, x, r);
        stepCycle();
        data_in_valid = 1'b0;
        checkOutput($sformatf("%s_validAtK", tag), 64'(data_out_valid), 64'd0);
        stepCycle();
        checkOutput($sformatf("%s_validAtK1", tag), 64'(data_out_valid), 64'd0);
        stepCycle();
        checkOutput($sformatf("%s_validAtK2", tag), 64'(data_out_valid), 64'd1);
        checkOutput($sformatf("%s_data", tag), data_out, {4{expVal}});
        checkOutput($sformatf("%s_satCount", tag), 64'(sat_count), 64'(expSat));
    endtask

    function automatic logic [63:0] streamExp(input int i);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            v[c*16 +: 16] = 16'(2 * (i + c) + 100 * i + 5);
        end
        return v;
    endfunction

    // Scoreboard for the streaming test. A transfer is seen at the negedge
    // before the edge on which it completes.
    always @(negedge clk) begin
        if (collectEn && data_out_valid && data_out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("streamExtraBeat", 64'd1, 64'd0);
            end else begin
                checkOutput($sformatf("streamBeat%0d", gotCount), data_out, expQ.pop_front());
            end
            gotCount++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] expSatLo;
        logic [15:0] expNegRound;
        logic [15:0] satAfter;
        logic [63:0] frozenVal;
        logic        accepted;
        int          i;
        int          cyc;

`ifdef BN_RES_RELU_EN
        expSatLo    = 16'h0000;
        expNegRound = 16'h0000;
        satAfter    = 16'd1;
`else
        expSatLo    = 16'h8000;
        expNegRound = 16'hFFFD;
        satAfter    = 16'd2;
`endif

        rstn           = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        data_in        = '0;
        bn_a           = '0;
        bn_b           = '0;
        res            = '0;

        // Reset state, checked with the output not ready: input ready must
        // still read high because nothing is held at the output.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", 64'(data_out_valid), 64'd0);
        checkOutput("rstData", data_out, 64'd0);
        checkOutput("rstSatCount", 64'(sat_count), 64'd0);
        checkOutput("rstReady", 64'(data_in_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        stepCycle();

        // 256*5 = 1280; +128 gives 1408; >>8 gives 5; +3 gives 8.
        runSingle("basic", 16'd256, 16'd0, 6'd5, 16'd3, 16'd8, 16'd0);
        // 32767*63 + 32767 + 128 = 2097216; >>8 gives 8192; +32767 clips high.
        runSingle("satHi", 16'h7FFF, 16'h7FFF, 6'd63, 16'h7FFF, 16'h7FFF, 16'd1);
        // -32768*63 - 32768 + 128 = -2097024; >>8 gives -8192; -32768 clips low.
        runSingle("satLo", 16'h8000, 16'h8000, 6'd63, 16'h8000, expSatLo, satAfter);
        // 256 - 1024 + 128 = -640; >>8 gives -3 (floor).
        runSingle("negRound", 16'd256, 16'hFC00, 6'd1, 16'd0, expNegRound, satAfter);

        // Ten back-to-back beats, with a five-cycle output stall mid-stream.
        stepCycle();
        expQ.delete();
        gotCount  = 0;
        collectEn = 1'b1;
        i         = 0;
        cyc       = 0;
        frozenVal = '0;
        while (i < 10 && cyc < 40) begin
            for (int c = 0; c < CH; c++) begin
                data_in[c] = 6'(i + c);
                bn_a[c]    = 16'd512;
                bn_b[c]    = 16'd0;
                res[c]     = 16'(i * 100 + 5);
            end
            data_in_valid  = 1'b1;
            data_out_ready = !(cyc >= 5 && cyc < 10);
            #1;
            if (cyc >= 5 && cyc < 10) begin
                checkOutput($sformatf("holdReady%0d", cyc), 64'(data_in_ready), 64'd0);
                if (cyc == 5) begin
                    frozenVal = data_out;
                end else begin
                    checkOutput($sformatf("holdData%0d", cyc), data_out, frozenVal);
                    checkOutput($sformatf("holdValid%0d", cyc), 64'(data_out_valid), 64'd1);
                end
            end
            accepted = data_in_valid && data_in_ready;
            if (accepted) expQ.push_back(streamExp(i));
            @(posedge clk);
            #1;
            if (accepted) i++;
            cyc++;
        end
        checkOutput("streamAccepted", 64'(i), 64'd10);
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        for (int w = 0; w < 20 && gotCount < 10; w++) stepCycle();
        repeat (3) stepCycle();
        checkOutput("streamCount", 64'(gotCount), 64'd10);
        collectEn = 1'b0;
        checkOutput("streamSatCount", 64'(sat_count), 64'(satAfter));

        // Fill the pipe with three beats, then reset while they are in flight.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'd256, 16'd0, 6'(10 + k), 16'd0);
            stepCycle();
        end
        data_in_valid = 1'b0;
        checkOutput("preRstValid", 64'(data_out_valid), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("midRstValid", 64'(data_out_valid), 64'd0);
        checkOutput("midRstData", data_out, 64'd0);
        checkOutput("midRstSatCount", 64'(sat_count), 64'd0);
        checkOutput("midRstReady", 64'(data_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        stepCycle();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("postRstIdle%0d", k), 64'(data_out_valid), 64'd0);
            stepCycle();
        end
        runSingle("afterRst", 16'd256, 16'd0, 6'd2, 16'd0, 16'd2, 16'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
